// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search datapath and its controller.
package rc4_pkg;

    localparam int               KEY_W   = 24;
    localparam logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF;

    typedef enum logic [4:0] {
        IDLE,
        INIT_REQ, INIT_WAIT, INIT_DRAIN,
        SHUF_REQ, SHUF_WAIT, SHUF_DRAIN,
        DEC_REQ,  DEC_WAIT,  DEC_DRAIN,
        STEP_REQ, STEP_WAIT, STEP_DRAIN,
        CHECK,
        FOUND,
        EXHAUSTED,
        HUNG
    } ctrl_state_t;

    // Which engine the shared handshake block is currently talking to.
    typedef enum logic [1:0] {
        PH_INIT,
        PH_SHUF,
        PH_DEC,
        PH_STEP
    } phase_t;

    // Position inside one engine handshake.
    typedef enum logic [1:0] {
        HS_NONE,
        HS_REQ,
        HS_WAIT,
        HS_DRAIN
    } hs_stage_t;

    function automatic phase_t phase_of(input ctrl_state_t s);
        case (s)
            SHUF_REQ, SHUF_WAIT, SHUF_DRAIN: return PH_SHUF;
            DEC_REQ,  DEC_WAIT,  DEC_DRAIN:  return PH_DEC;
            STEP_REQ, STEP_WAIT, STEP_DRAIN: return PH_STEP;
            default:                         return PH_INIT;
        endcase
    endfunction

    function automatic hs_stage_t stage_of(input ctrl_state_t s);
        case (s)
            INIT_REQ,   SHUF_REQ,   DEC_REQ,   STEP_REQ:   return HS_REQ;
            INIT_WAIT,  SHUF_WAIT,  DEC_WAIT,  STEP_WAIT:  return HS_WAIT;
            INIT_DRAIN, SHUF_DRAIN, DEC_DRAIN, STEP_DRAIN: return HS_DRAIN;
            default:                                       return HS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/engine_handshake.sv
// Time-shared start/finish handshake with a hang watchdog. The controller
// selects the engine (phase) and the handshake position (stage); this block
// produces the start request, the "advance" condition and the timeout flag.
module engine_handshake
    import rc4_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic      clk,
    input  logic      reset,
    input  phase_t    phase,
    input  hs_stage_t stage,
    input  logic      init_finish,
    input  logic      shuf_finish,
    input  logic      dec_finish,
    input  logic      step_finish,
    output logic      start,
    output logic      done,
    output logic      timeout
);

    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd;
    logic            finish_sel;
    logic            watching;

    assign watching = (stage == HS_WAIT) || (stage == HS_DRAIN);

    // Route the finish line of the engine currently being served.
    always_comb begin
        finish_sel = 1'b0;
        case (phase)
            PH_INIT: finish_sel = init_finish;
            PH_SHUF: finish_sel = shuf_finish;
            PH_DEC:  finish_sel = dec_finish;
            PH_STEP: finish_sel = step_finish;
            default: finish_sel = 1'b0;
        endcase
    end

    // Watchdog: the request cycle is count 0, so the first wait cycle reads 1
    // and the limit is hit exactly TIMEOUT-1 cycles after the start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd <= '0;
        end else if (stage == HS_REQ) begin
            wd <= WD_W'(1);
        end else if (watching && (wd != WD_LAST)) begin
            wd <= wd + 1'b1;
        end
    end

    assign start   = (stage == HS_REQ);
    assign done    = ((stage == HS_WAIT) && finish_sel) ||
                     ((stage == HS_DRAIN) && !finish_sel);
    assign timeout = watching && (wd == WD_LAST);

endmodule

// File: rtl/key_search_ctrl.sv
// Top-level sequencer for the RC4 brute-force key search: walks each candidate
// key through init, shuffle, decrypt/check and key step, and owns the key,
// the attempt counter and the sticky result flags.
module key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int               KEY_W   = rc4_pkg::KEY_W,
    parameter logic [KEY_W-1:0] KEY_MAX = rc4_pkg::KEY_MAX,
    parameter int               TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_base,
    output logic             init_start,
    input  logic             init_finish,
    output logic             shuf_start,
    input  logic             shuf_finish,
    output logic             dec_start,
    input  logic             dec_finish,
    input  logic             dec_pass,
    output logic             step_start,
    input  logic             step_finish,
    input  logic [KEY_W-1:0] key_next,
    output logic [KEY_W-1:0] secret_key,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic             hung,
    output logic [KEY_W-1:0] attempts
);

    ctrl_state_t state, state_n;
    phase_t      hs_phase;
    hs_stage_t   hs_stage;
    logic        hs_start, hs_done, hs_timeout;
    logic        load_base, load_next, latch_pass, count_attempt;
    logic        pass_q;

    assign hs_phase = phase_of(state);
    assign hs_stage = stage_of(state);

    engine_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk         (clk),
        .reset       (reset),
        .phase       (hs_phase),
        .stage       (hs_stage),
        .init_finish (init_finish),
        .shuf_finish (shuf_finish),
        .dec_finish  (dec_finish),
        .step_finish (step_finish),
        .start       (hs_start),
        .done        (hs_done),
        .timeout     (hs_timeout)
    );

    // Next-state and per-cycle control strobes; abort overrides everything.
    always_comb begin
        state_n       = state;
        load_base     = 1'b0;
        load_next     = 1'b0;
        latch_pass    = 1'b0;
        count_attempt = 1'b0;
        case (state)
            IDLE, FOUND, EXHAUSTED, HUNG: begin
                if (go) begin
                    load_base = 1'b1;
                    state_n   = INIT_REQ;
                end
            end
            INIT_REQ:   state_n = INIT_WAIT;
            INIT_WAIT:  if (hs_done) state_n = INIT_DRAIN; else if (hs_timeout) state_n = HUNG;
            INIT_DRAIN: if (hs_done) state_n = SHUF_REQ;   else if (hs_timeout) state_n = HUNG;
            SHUF_REQ:   state_n = SHUF_WAIT;
            SHUF_WAIT:  if (hs_done) state_n = SHUF_DRAIN; else if (hs_timeout) state_n = HUNG;
            SHUF_DRAIN: if (hs_done) state_n = DEC_REQ;    else if (hs_timeout) state_n = HUNG;
            DEC_REQ:    state_n = DEC_WAIT;
            DEC_WAIT: begin
                if (hs_done) begin
                    latch_pass = 1'b1;
                    state_n    = DEC_DRAIN;
                end else if (hs_timeout) begin
                    state_n = HUNG;
                end
            end
            DEC_DRAIN:  if (hs_done) state_n = CHECK;      else if (hs_timeout) state_n = HUNG;
            CHECK: begin
                count_attempt = 1'b1;
                if (pass_q)                     state_n = FOUND;
                else if (secret_key == KEY_MAX) state_n = EXHAUSTED;
                else                            state_n = STEP_REQ;
            end
            STEP_REQ:   state_n = STEP_WAIT;
            STEP_WAIT: begin
                if (hs_done) begin
                    load_next = 1'b1;
                    state_n   = STEP_DRAIN;
                end else if (hs_timeout) begin
                    state_n = HUNG;
                end
            end
            STEP_DRAIN: if (hs_done) state_n = INIT_REQ;   else if (hs_timeout) state_n = HUNG;
            default:    state_n = IDLE;
        endcase
        if (abort) begin
            state_n       = IDLE;
            load_base     = 1'b0;
            load_next     = 1'b0;
            latch_pass    = 1'b0;
            count_attempt = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Candidate key: loaded on go and on a completed key step only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          secret_key <= '0;
        else if (load_base) secret_key <= key_base;
        else if (load_next) secret_key <= key_next;
    end

    // Attempts counter, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               attempts <= '0;
        else if (load_base)                      attempts <= '0;
        else if (count_attempt && !(&attempts))  attempts <= attempts + 1'b1;
    end

    // Decrypt verdict, captured on the first cycle dec_finish is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           pass_q <= 1'b0;
        else if (latch_pass) pass_q <= dec_pass;
    end

    // Sticky result flags track the terminal state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            hung      <= 1'b0;
        end else begin
            found     <= (state_n == FOUND);
            exhausted <= (state_n == EXHAUSTED);
            hung      <= (state_n == HUNG);
        end
    end

    assign busy       = !((state == IDLE) || (state == FOUND) ||
                          (state == EXHAUSTED) || (state == HUNG));
    assign init_start = hs_start && !abort && (hs_phase == PH_INIT);
    assign shuf_start = hs_start && !abort && (hs_phase == PH_SHUF);
    assign dec_start  = hs_start && !abort && (hs_phase == PH_DEC);
    assign step_start = hs_start && !abort && (hs_phase == PH_STEP);

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl with stub engines and a result scoreboard.
module tb_key_search_ctrl;

    localparam int KW = 24;
    localparam int TO = 4096;

    logic          clk = 1'b0;
    logic          reset, go, abort;
    logic [KW-1:0] key_base;
    logic          init_start, shuf_start, dec_start, step_start;
    logic          init_finish, shuf_finish, dec_finish, step_finish;
    logic          dec_pass;
    logic [KW-1:0] key_next, secret_key, attempts;
    logic          busy, found, exhausted, hung;

    always #5 clk = ~clk;

    key_search_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .abort       (abort),
        .key_base    (key_base),
        .init_start  (init_start),
        .init_finish (init_finish),
        .shuf_start  (shuf_start),
        .shuf_finish (shuf_finish),
        .dec_start   (dec_start),
        .dec_finish  (dec_finish),
        .dec_pass    (dec_pass),
        .step_start  (step_start),
        .step_finish (step_finish),
        .key_next    (key_next),
        .secret_key  (secret_key),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .hung        (hung),
        .attempts    (attempts)
    );

    // ---------------- stub engines ----------------
    int            lat;
    int            hold [4];
    logic [3:0]    never;
    logic          pass_en;
    logic [KW-1:0] pass_key;
    logic [3:0]    st_v, fin_v;
    int            dly [4];
    int            hl  [4];

    assign st_v        = {step_start, dec_start, shuf_start, init_start};
    assign init_finish = fin_v[0];
    assign shuf_finish = fin_v[1];
    assign dec_finish  = fin_v[2];
    assign step_finish = fin_v[3];
    assign dec_pass    = pass_en && (secret_key == pass_key);
    assign key_next    = secret_key + 24'd1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fin_v <= '0;
            for (int i = 0; i < 4; i++) begin
                dly[i] <= 0;
                hl[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (st_v[i]) begin
                    dly[i] <= lat;
                end else if (dly[i] > 0) begin
                    dly[i] <= dly[i] - 1;
                    if (dly[i] == 1 && !never[i]) begin
                        fin_v[i] <= 1'b1;
                        hl[i]    <= hold[i];
                    end
                end else if (fin_v[i]) begin
                    hl[i] <= hl[i] - 1;
                    if (hl[i] <= 1) fin_v[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- start-pulse monitor ----------------
    int         n_start [4];
    int         viol;
    int         cyc;
    logic [3:0] st_prev;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        st_prev <= reset ? 4'b0 : st_v;
        if (!reset) begin
            if ($countones(st_v) > 1)  viol <= viol + 1;
            if ((st_v & st_prev) != 0) viol <= viol + 1;
            for (int i = 0; i < 4; i++)
                if (st_v[i]) n_start[i] <= n_start[i] + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string         tag;
        logic          f, e, h;
        logic [KW-1:0] key, att;
        int            ni, ns, nd, nt;
    } exp_t;

    exp_t sb[$];
    int   base_n [4];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input string tag, input logic f, input logic e, input logic h,
                                input logic [KW-1:0] key, input logic [KW-1:0] att,
                                input int ni, input int ns, input int nd, input int nt);
        exp_t r;
        r.tag = tag; r.f = f; r.e = e; r.h = h; r.key = key; r.att = att;
        r.ni = ni; r.ns = ns; r.nd = nd; r.nt = nt;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) base_n[i] = n_start[i];
    endtask

    task automatic launch(input logic [KW-1:0] base);
        snap();
        @(posedge clk); #1;
        key_base = base;
        go       = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_start(input int idx, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (st_v[idx]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_terminal(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && (found || exhausted || hung)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_result(input int budget);
        exp_t e;
        bit   ok;
        wait_terminal(budget, ok);
        e = sb.pop_front();
        chk({e.tag, "_terminal"},  32'(ok), 32'd1);
        chk({e.tag, "_found"},     32'(found), 32'(e.f));
        chk({e.tag, "_exhausted"}, 32'(exhausted), 32'(e.e));
        chk({e.tag, "_hung"},      32'(hung), 32'(e.h));
        chk({e.tag, "_key"},       32'(secret_key), 32'(e.key));
        chk({e.tag, "_attempts"},  32'(attempts), 32'(e.att));
        chk({e.tag, "_n_init"},    32'(n_start[0] - base_n[0]), 32'(e.ni));
        chk({e.tag, "_n_shuf"},    32'(n_start[1] - base_n[1]), 32'(e.ns));
        chk({e.tag, "_n_dec"},     32'(n_start[2] - base_n[2]), 32'(e.nd));
        chk({e.tag, "_n_step"},    32'(n_start[3] - base_n[3]), 32'(e.nt));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int c0, c1;
        reset    = 1'b1;
        go       = 1'b0;
        abort    = 1'b0;
        key_base = '0;
        lat      = 3;
        for (int i = 0; i < 4; i++) hold[i] = 1;
        never    = 4'b0000;
        pass_en  = 1'b0;
        pass_key = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_key",   32'(secret_key), 32'd0);
        chk("rst_att",   32'(attempts), 32'd0);
        chk("rst_flags", 32'({found, exhausted, hung}), 32'd0);
        chk("rst_start", 32'(st_v), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Pass on the first key; a go pulse mid-search must be ignored
        pass_en  = 1'b1;
        pass_key = 24'h000010;
        sb.push_back(mk("first", 1'b1, 1'b0, 1'b0, 24'h000010, 24'd1, 1, 1, 1, 0));
        launch(24'h000010);
        repeat (3) @(posedge clk);
        #1;
        key_base = 24'h000123;
        go       = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check_result(500);

        // Last two keys of the space, never passing
        pass_en = 1'b0;
        sb.push_back(mk("exh", 1'b0, 1'b1, 1'b0, 24'h3FFFFF, 24'd2, 2, 2, 2, 1));
        launch(24'h3FFFFE);
        check_result(1000);

        // Long decrypt finish pulse, pass on third key from 0
        hold[2]  = 5;
        pass_en  = 1'b1;
        pass_key = 24'd2;
        sb.push_back(mk("hold5", 1'b1, 1'b0, 1'b0, 24'd2, 24'd3, 3, 3, 3, 2));
        launch(24'd0);
        check_result(1500);

        // Shuffle engine never finishes
        hold[2] = 1;
        never   = 4'b0010;
        sb.push_back(mk("hang", 1'b0, 1'b0, 1'b1, 24'h000040, 24'd0, 1, 1, 0, 0));
        launch(24'h000040);
        wait_start(1, 200, ok);
        chk("hang_shuf_start_seen", 32'(ok), 32'd1);
        c0 = cyc;
        c1 = cyc;
        for (int i = 0; i < TO + 50; i++) begin
            @(negedge clk);
            if (hung) begin
                c1 = cyc;
                break;
            end
        end
        chk("hang_latency", 32'(c1 - c0), 32'(TO));
        check_result(10);
        chk("hang_busy", 32'(busy), 32'd0);

        // Abort from a terminal state clears the sticky flag, key held
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_term_hung", 32'(hung), 32'd0);
        chk("abort_term_key",  32'(secret_key), 32'h40);

        // Abort and go together while waiting on decrypt
        never   = 4'b0100;
        pass_en = 1'b0;
        launch(24'h000077);
        wait_start(2, 200, ok);
        chk("abort_dec_start_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        snap();
        abort    = 1'b1;
        go       = 1'b1;
        key_base = 24'h000099;
        @(negedge clk);
        chk("abort_cycle_start", 32'(st_v), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        go    = 1'b0;
        @(negedge clk);
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_key",   32'(secret_key), 32'h77);
        chk("abort_flags", 32'({found, exhausted, hung}), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_no_starts", 32'((n_start[0] - base_n[0]) + (n_start[1] - base_n[1]) +
                                   (n_start[2] - base_n[2]) + (n_start[3] - base_n[3])), 32'd0);

        // Asynchronous reset while waiting on the shuffle engine
        never = 4'b0010;
        launch(24'h000055);
        wait_start(1, 200, ok);
        chk("rst_mid_shuf_start_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("rst_mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_async_busy", 32'(busy), 32'd0);
        chk("rst_mid_async_key",  32'(secret_key), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy",  32'(busy), 32'd0);
        chk("rst_mid_key",   32'(secret_key), 32'd0);
        chk("rst_mid_att",   32'(attempts), 32'd0);
        chk("rst_mid_flags", 32'({found, exhausted, hung}), 32'd0);
        chk("rst_mid_start", 32'(st_v), 32'd0);

        // Start-pulse invariants over the whole run
        chk("start_invariants", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
